// File: rtl/hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage OTTER pipeline: forwarding, load-use stall, branch flush, memory wait FSM.
// Hazard outputs are combinational on the current cycle; FSM state, wait counter, MemErr and perf counters update on clk.
// A pending data-memory access freezes every stage until MemAckM or the wait-cycle timeout releases it.
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemAckM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  StallW,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  MemErr,
    output logic [CNT_W-1:0]      StallCnt,
    output logic [CNT_W-1:0]      FlushCnt
);

    // Wait counter only needs to reach MEM_TIMEOUT; keep one bit when timeout is disabled.
    localparam int WC_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

    typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WC_W-1:0] waitcnt;
    logic            timeout_hit;
    logic            mem_stall;
    logic            lw_stall;
    logic            any_stall;

    // waitcnt equals the number of cycles already stalled for the current access,
    // so hitting MEM_TIMEOUT here means exactly MEM_TIMEOUT stall cycles have elapsed.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (waitcnt == TIMEOUT_V);
    assign mem_stall   = MemReqM && !MemAckM && !timeout_hit;
    assign lw_stall    = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign any_stall   = StallF | StallD | StallE | StallM | StallW;

    // State register: RUN / MWAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: enter MWAIT on an unanswered request, leave on ack or forced release.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mem_stall) state_nxt = MWAIT;
            MWAIT:   if (MemAckM || timeout_hit) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Hazard outputs: forwarding muxes, stalls and flushes for the current cycle.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        if (!reset) begin
            // M result is younger than W, so it wins when both match.
            if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
            if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;

            if (mem_stall) begin
                // Whole pipe frozen; branch and load-use decisions stay in E and are
                // re-evaluated on the release cycle, so no flush here.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = PCSrcE | lw_stall;
            end
        end
    end

    // Wait counter: counts consecutive memory-stall cycles, cleared whenever not stalling.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitcnt <= '0;
        end else if (!mem_stall) begin
            waitcnt <= '0;
        end else if (MEM_TIMEOUT != 0) begin
            waitcnt <= waitcnt + 1'b1;
        end
    end

    // Sticky error: set only on a genuine timeout (an ack in the same cycle wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            MemErr <= 1'b0;
        end else if (MemReqM && !MemAckM && timeout_hit) begin
            MemErr <= 1'b1;
        end
    end

    // Saturating perf counters for stall cycles and branch-flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (any_stall && (StallCnt != '1)) StallCnt <= StallCnt + 1'b1;
            if (FlushD && (FlushCnt != '1))    FlushCnt <= FlushCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: main instance (32-bit counters, timeout 4) plus a 2-bit-counter instance for saturation.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, well away from the rising edge.
// Both instances share all inputs.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemAckM;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;
    logic [31:0] StallCnt, FlushCnt;

    logic [1:0] s_ForwardAE, s_ForwardBE;
    logic       s_StallF, s_StallD, s_StallE, s_StallM, s_StallW, s_FlushD, s_FlushE, s_MemErr;
    logic [1:0] s_StallCnt, s_FlushCnt;

    logic [4:0] stalls;
    assign stalls = {StallF, StallD, StallE, StallM, StallW};

    int n_chk  = 0;
    int n_fail = 0;

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2), .MEM_TIMEOUT(0)) dut_sat (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM), .StallW(s_StallW),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .MemErr(s_MemErr),
        .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
    endtask

    // Leaves the caller at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
        LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; MemReqM = 1'b1;
        #1;
        n_chk++; if ({FlushD, FlushE} !== 2'b11) begin n_fail++; $display("FAIL reset_flush: got %b expected 11", {FlushD, FlushE}); end
        n_chk++; if (stalls !== 5'b00000) begin n_fail++; $display("FAIL reset_stalls: got %b expected 00000", stalls); end
        n_chk++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd: got %b expected 0000", {ForwardAE, ForwardBE}); end
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        #1;
        n_chk++; if (StallCnt !== 32'd0) begin n_fail++; $display("FAIL reset_stallcnt: got %0d expected 0", StallCnt); end
        n_chk++; if (FlushCnt !== 32'd0) begin n_fail++; $display("FAIL reset_flushcnt: got %0d expected 0", FlushCnt); end
        n_chk++; if (MemErr !== 1'b0) begin n_fail++; $display("FAIL reset_memerr: got %b expected 0", MemErr); end
        n_chk++; if ({FlushD, FlushE} !== 2'b00) begin n_fail++; $display("FAIL idle_flush: got %b expected 00", {FlushD, FlushE}); end
    endtask

    task automatic test_forward();
        do_reset();
        RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
        #1;
        n_chk++; if (ForwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_m_prio_a: got %b expected 10", ForwardAE); end
        n_chk++; if (ForwardBE !== 2'b10) begin n_fail++; $display("FAIL fwd_m_prio_b: got %b expected 10", ForwardBE); end
        RdM = 5'd0;
        #1;
        n_chk++; if (ForwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_rdm_zero: got %b expected 01", ForwardAE); end
        RdM = 5'd5; Rs2E = 5'd3; RdW = 5'd3;
        #1;
        n_chk++; if ({ForwardAE, ForwardBE} !== 4'b1001) begin n_fail++; $display("FAIL fwd_split: got %b expected 1001", {ForwardAE, ForwardBE}); end
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        #1;
        n_chk++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_fail++; $display("FAIL fwd_no_write: got %b expected 0000", {ForwardAE, ForwardBE}); end
        RegWriteW = 1'b1; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        #1;
        n_chk++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0: got %b expected 0000", {ForwardAE, ForwardBE}); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd3;
        #1;
        n_chk++; if (stalls !== 5'b11000) begin n_fail++; $display("FAIL lu_stalls: got %b expected 11000", stalls); end
        n_chk++; if ({FlushD, FlushE} !== 2'b01) begin n_fail++; $display("FAIL lu_flush: got %b expected 01", {FlushD, FlushE}); end
        RdE = 5'd0; Rs1D = 5'd0;
        #1;
        n_chk++; if ({stalls, FlushE} !== 6'b000000) begin n_fail++; $display("FAIL lu_rd_zero: got %b expected 000000", {stalls, FlushE}); end
        RdE = 5'd7; LoadE = 1'b0;
        #1;
        n_chk++; if ({stalls, FlushE} !== 6'b000000) begin n_fail++; $display("FAIL lu_not_load: got %b expected 000000", {stalls, FlushE}); end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        PCSrcE = 1'b1;
        #1;
        n_chk++; if ({FlushD, FlushE, stalls} !== 7'b1100000) begin n_fail++; $display("FAIL br_flush: got %b expected 1100000", {FlushD, FlushE, stalls}); end
        @(negedge clk);
        PCSrcE = 1'b0;
        #1;
        n_chk++; if (FlushCnt !== 32'd1) begin n_fail++; $display("FAIL br_flushcnt: got %0d expected 1", FlushCnt); end
        n_chk++; if ({FlushD, FlushE} !== 2'b00) begin n_fail++; $display("FAIL br_one_cycle: got %b expected 00", {FlushD, FlushE}); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        MemReqM = 1'b1; MemAckM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            PCSrcE = (i == 1);
            #1;
            n_chk++; if (stalls !== 5'b11111) begin n_fail++; $display("FAIL mw_stall[%0d]: got %b expected 11111", i, stalls); end
            n_chk++; if ({FlushD, FlushE} !== 2'b00) begin n_fail++; $display("FAIL mw_noflush[%0d]: got %b expected 00", i, {FlushD, FlushE}); end
            @(negedge clk);
        end
        MemAckM = 1'b1; PCSrcE = 1'b1;
        #1;
        n_chk++; if (stalls !== 5'b00000) begin n_fail++; $display("FAIL mw_ack_release: got %b expected 00000", stalls); end
        n_chk++; if ({FlushD, FlushE} !== 2'b11) begin n_fail++; $display("FAIL mw_ack_flush: got %b expected 11", {FlushD, FlushE}); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_chk++; if (StallCnt !== 32'd3) begin n_fail++; $display("FAIL mw_stallcnt: got %0d expected 3", StallCnt); end
        n_chk++; if (FlushCnt !== 32'd1) begin n_fail++; $display("FAIL mw_flushcnt: got %0d expected 1", FlushCnt); end
        MemReqM = 1'b1; MemAckM = 1'b1;
        #1;
        n_chk++; if (stalls !== 5'b00000) begin n_fail++; $display("FAIL mw_first_ack: got %b expected 00000", stalls); end
        @(negedge clk);
        MemAckM = 1'b0;
        #1;
        n_chk++; if (StallCnt !== 32'd3) begin n_fail++; $display("FAIL mw_first_ack_cnt: got %0d expected 3", StallCnt); end
        n_chk++; if (stalls !== 5'b11111) begin n_fail++; $display("FAIL mw_run_after_ack: got %b expected 11111", stalls); end
        MemAckM = 1'b1;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1'b1; MemAckM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (stalls !== 5'b11111) begin n_fail++; $display("FAIL to_stall[%0d]: got %b expected 11111", i, stalls); end
            @(negedge clk);
        end
        #1;
        n_chk++; if (stalls !== 5'b00000) begin n_fail++; $display("FAIL to_release: got %b expected 00000", stalls); end
        n_chk++; if (MemErr !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b expected 0", MemErr); end
        @(negedge clk);
        MemReqM = 1'b0;
        #1;
        n_chk++; if (MemErr !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b expected 1", MemErr); end
        n_chk++; if (StallCnt !== 32'd4) begin n_fail++; $display("FAIL to_stallcnt: got %0d expected 4", StallCnt); end
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++; if (MemErr !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b expected 1", MemErr); end
    endtask

    // Runs straight after test_timeout so MemErr and StallCnt are non-zero going in.
    task automatic test_reset_in_mwait();
        @(negedge clk);
        MemReqM = 1'b1; MemAckM = 1'b0;
        @(negedge clk);
        #1;
        n_chk++; if (stalls !== 5'b11111) begin n_fail++; $display("FAIL rm_in_wait: got %b expected 11111", stalls); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_chk++; if (stalls !== 5'b00000) begin n_fail++; $display("FAIL rm_reset_stall: got %b expected 00000", stalls); end
        @(negedge clk);
        reset = 1'b0;
        MemReqM = 1'b0;
        #1;
        n_chk++; if (StallCnt !== 32'd0) begin n_fail++; $display("FAIL rm_stallcnt: got %0d expected 0", StallCnt); end
        n_chk++; if (MemErr !== 1'b0) begin n_fail++; $display("FAIL rm_memerr: got %b expected 0", MemErr); end
        n_chk++; if (stalls !== 5'b00000) begin n_fail++; $display("FAIL rm_stall_drop: got %b expected 00000", stalls); end
        @(negedge clk);
        MemReqM = 1'b1; MemAckM = 1'b0;
        #1;
        n_chk++; if (stalls !== 5'b11111) begin n_fail++; $display("FAIL rm_fresh_req: got %b expected 11111", stalls); end
        MemAckM = 1'b1;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
        end
        clear_inputs();
        #1;
        n_chk++; if (StallCnt !== 32'd5) begin n_fail++; $display("FAIL sat_wide_stall: got %0d expected 5", StallCnt); end
        n_chk++; if (s_StallCnt !== 2'd3) begin n_fail++; $display("FAIL sat_stallcnt: got %0d expected 3", s_StallCnt); end
        PCSrcE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        clear_inputs();
        #1;
        n_chk++; if (FlushCnt !== 32'd4) begin n_fail++; $display("FAIL sat_wide_flush: got %0d expected 4", FlushCnt); end
        n_chk++; if (s_FlushCnt !== 2'd3) begin n_fail++; $display("FAIL sat_flushcnt: got %0d expected 3", s_FlushCnt); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_in_mwait();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
